decode_stage_pipelined: RTL and testbench
=========================================

// Module: decode_stage_pipelined
// PURPOSE
//  Decode stage for the 16-bit CR16-style datapath. Parametrised in register count and write-back delay.
//  Holds the instruction register (IR), which can also be loaded or read out through a scan chain.
//  Decodes RF addresses and datapath control, keeps the Z/F/N flag register, resolves Bcond/Jcond,
//  and runs a load-use stall FSM with a valid/ready fetch handshake. Sits between imem fetch and the RF/ALU.
// PARAMETERS
//  NUM_REGS   16  register count; RF addresses are one-hot, NUM_REGS bits wide (2..16; fields stay 4 bits)
//  WB_DELAY    1  registered stages on {wr_en, wr_addr} before the RF (0..3; 0 = combinational)
//  LOAD_LAT    1  extra stall cycles while a LOAD is in the IR (0..7)
// PORTS
//  clk          in   1         clock, rising edge only
//  global_reset in   1         synchronous, active-high
//  instr_in     in   16        instruction from imem
//  instr_valid  in   1         instr_in is valid
//  instr_ready  out  1         decoder accepts instr_in this cycle
//  Z_flag_in / F_flag_in / N_flag_in  in  1 each  ALU flags for the instruction currently in the IR
//  scan_en      in   1         IR shifts, MSB first
//  scan_in      in   1         scan data in
//  scan_out     out  1         IR[15]
//  rd_addr_a    out  NUM_REGS  one-hot Rsrc (IR[3:0])
//  rd_addr_b    out  NUM_REGS  one-hot Rdest (IR[11:8])
//  wr_addr      out  NUM_REGS  one-hot write address, delayed by WB_DELAY
//  wr_en        out  1         RF write enable, delayed by WB_DELAY
//  alu_op       out  2         00 add, 01 and, 10 or, 11 xor
//  cin, sel_b_imm, inv_b, sel_mov  out  1 each  carry-in, use Imm, invert B, pass-B
//  res_sel      out  2         00 mem, 01 alu, 10 shifter, 11 link (PC+1)
//  shift_mode   out  2         00 LSH, 01 LSHI, 10 LUI
//  imm          out  8         IR[7:0]
//  mem_ceb, mem_web  out  1 each  active-low imem/dmem enables
//  bcond, jcond, jal  out  1 each  branch taken, jump taken, jump-and-link
//  disp         out  8         IR[7:0] on Bcond
//  stall        out  1         load-use stall active
// BEHAVIOUR
//  Reset: IR=0, ir_valid=0, flags=0, FSM=RUN, WB pipe cleared. Every output 0 except mem_ceb=mem_web=1.
//   instr_ready is 1 from the first post-reset cycle.
//  IR load: on instr_valid&instr_ready&!scan_en, IR<=instr_in and ir_valid<=1 on the next edge.
//   Without a load, ir_valid<=0, unless the IR is held by stall.
//  Scan: while scan_en, IR<={IR[14:0],scan_in} each cycle and instr_ready=0.
//   All side-effecting outputs (wr_en, mem_ceb/web, bcond, jcond, jal) are forced inactive.
//   ir_valid is cleared. 16 shifts fully load or read out the IR.
//  Decode: combinational from the IR, gated by ir_valid. Invalid IR acts as a NOP (no write, no mem, no branch).
//   opc=IR[15:12], ext=IR[7:4].
//   Register-register (opc 0000), ext:
//    ADD 0101, SUB 1001 (inv_b, cin), CMP 1011 (as SUB, wr_en=0), MOV 1101 (sel_mov), AND 0001, OR 0010, XOR 0011.
//   Immediate forms: opcodes 0101/1001/1011/0001/0010/0011 with sel_b_imm=1. MOVI is 1101.
//   Shifts: 1000 (ext 0100 LSH, 000x LSHI). LUI is 1111.
//   opc 0100, ext: LOAD 0000 (mem_ceb=0, res_sel 00), STOR 0100 (mem_ceb=mem_web=0, wr_en=0),
//    JAL 1000 (wr_en, res_sel 11, jal=1), Jcond 1100.
//   opc 1100 = Bcond.
//   Undefined encodings decode as a NOP.
//  Conditions (IR[11:8], from the flag register):
//   0000 Z, 0001 !Z, 0110 N, 0111 !N, 1000 F, 1001 !F, 1100 !N&!Z, 1101 N|Z, 1110 always.
//   1111 and all other codes: never.
//  Flags: latch Z/F/N_flag_in on the edge that ends a valid ADD/SUB/CMP (reg or imm) in the IR.
//   No latch while stalled, in scan, or in reset.
//  Taken bcond or jcond: the next fetched word is squashed (ir_valid<=0 for one cycle). instr_ready stays 1.
//  Stall FSM:
//   RUN -> LWAIT when a valid LOAD is in the IR and LOAD_LAT>0; the counter loads LOAD_LAT-1.
//   In LWAIT: stall=1, instr_ready=0, IR held, wr_en held low until the final cycle.
//    The counter decrements each cycle; at 0, go to RUN and assert wr_en.
//   LOAD_LAT=0: no stall, LOAD writes back in the same cycle.
//   scan_en in LWAIT aborts to RUN.
//  WB pipe: {wr_en, wr_addr} pass through WB_DELAY registers. global_reset clears all stages (in-flight writes are dropped).
//  Reset mid-operation: reset dominates scan, stall and handshake in the same cycle.
// TESTING
//  T1 reset: global_reset 2 cycles -> all outputs at reset values, instr_ready=1 the cycle after release.
//  T2 ADD: instr_in=0x0251 (ADD R1->R2), valid -> rd_addr_a=0x0002, rd_addr_b=0x0004, alu_op=00.
//   wr_en/wr_addr=0x0004 appear WB_DELAY cycles later. Flags latched from Z_flag_in=1.
//  T3 Bcond: BEQ 0xC005 with Z=1 -> bcond=1, disp=0x05, following word squashed (no wr_en).
//   With Z=0 -> bcond=0, no squash.
//  T4 load-use: LOAD 0x4003, LOAD_LAT=2 -> stall=1 and instr_ready=0 for 2 cycles.
//   wr_en then pulses once, and the next word is accepted afterwards.
//  T5 scan: shift 0xD37F in with scan_en=1 (16 cycles) -> MOVI to R3 decoded.
//   Shifting 16 more cycles reads 0xD37F out on scan_out, MSB first. No wr_en during the scan.
//  T6 reset during LWAIT and during scan -> FSM=RUN, ir_valid=0, WB pipe empty on the next cycle.

Source files
------------

// File: rtl/decode_stage_pipelined.sv
// Decode stage for the 16-bit CR16-style datapath: scannable IR, instruction decode, Z/F/N flags,
// branch/jump resolution, load-use stall FSM and a write-back enable delayed by WB_DELAY stages.
module decode_stage_pipelined #(
    parameter int NUM_REGS = 16,
    parameter int WB_DELAY = 1,
    parameter int LOAD_LAT = 1
) (
    input  logic                clk,
    input  logic                global_reset,
    input  logic [15:0]         instr_in,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic                Z_flag_in,
    input  logic                F_flag_in,
    input  logic                N_flag_in,
    input  logic                scan_en,
    input  logic                scan_in,
    output logic                scan_out,
    output logic [NUM_REGS-1:0] rd_addr_a,
    output logic [NUM_REGS-1:0] rd_addr_b,
    output logic [NUM_REGS-1:0] wr_addr,
    output logic                wr_en,
    output logic [1:0]          alu_op,
    output logic                cin,
    output logic                sel_b_imm,
    output logic                inv_b,
    output logic                sel_mov,
    output logic [1:0]          res_sel,
    output logic [1:0]          shift_mode,
    output logic [7:0]          imm,
    output logic                mem_ceb,
    output logic                mem_web,
    output logic                bcond,
    output logic                jcond,
    output logic                jal,
    output logic [7:0]          disp,
    output logic                stall
);

    typedef enum logic {RUN = 1'b0, LWAIT = 1'b1} state_t;

    localparam bit         HAS_LAT  = (LOAD_LAT > 0);
    localparam logic [2:0] LAT_INIT = 3'(HAS_LAT ? LOAD_LAT - 1 : 0);

    logic [15:0] ir;
    logic        ir_valid;
    logic        z_q, f_q, n_q;
    state_t      state, state_next;
    logic [2:0]  cnt, cnt_next;

    logic [3:0]  opc, ext, cc, alu_code;
    logic        d_defined, d_wr, d_arith, d_load, d_stor, d_jal, d_jcond, d_bcond;
    logic [1:0]  d_alu_op, d_res_sel, d_shift_mode;
    logic        d_cin, d_inv_b, d_sel_b_imm, d_sel_mov;
    logic        cond_true, active, load_v, load_done, taken, wr_dec;
    logic [NUM_REGS-1:0] wr_addr_dec, wb_addr_out;
    logic        wb_en_out;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] idx);
        logic [NUM_REGS-1:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[i] = (idx == 4'(i));
        return v;
    endfunction

    assign opc      = ir[15:12];
    assign ext      = ir[7:4];
    assign cc       = ir[11:8];
    assign alu_code = (opc == 4'b0000) ? ext : opc;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        d_defined = 1'b0; d_wr = 1'b0; d_arith = 1'b0; d_load = 1'b0; d_stor = 1'b0;
        d_jal = 1'b0; d_jcond = 1'b0; d_bcond = 1'b0;
        d_alu_op = 2'b00; d_res_sel = 2'b00; d_shift_mode = 2'b00;
        d_cin = 1'b0; d_inv_b = 1'b0; d_sel_b_imm = 1'b0; d_sel_mov = 1'b0;
        case (opc)
            4'b0000, 4'b0101, 4'b1001, 4'b1011, 4'b1101, 4'b0001, 4'b0010, 4'b0011: begin
                // Register and immediate ALU forms share the same 4-bit operation code.
                case (alu_code)
                    4'b0101: begin d_defined = 1'b1; d_wr = 1'b1; d_arith = 1'b1; d_res_sel = 2'b01; end
                    4'b1001: begin d_defined = 1'b1; d_wr = 1'b1; d_arith = 1'b1; d_res_sel = 2'b01;
                                   d_inv_b = 1'b1; d_cin = 1'b1; end
                    4'b1011: begin d_defined = 1'b1; d_arith = 1'b1; d_res_sel = 2'b01;
                                   d_inv_b = 1'b1; d_cin = 1'b1; end
                    4'b1101: begin d_defined = 1'b1; d_wr = 1'b1; d_res_sel = 2'b01; d_sel_mov = 1'b1; end
                    4'b0001: begin d_defined = 1'b1; d_wr = 1'b1; d_res_sel = 2'b01; d_alu_op = 2'b01; end
                    4'b0010: begin d_defined = 1'b1; d_wr = 1'b1; d_res_sel = 2'b01; d_alu_op = 2'b10; end
                    4'b0011: begin d_defined = 1'b1; d_wr = 1'b1; d_res_sel = 2'b01; d_alu_op = 2'b11; end
                    default: ;
                endcase
                d_sel_b_imm = d_defined && (opc != 4'b0000);
            end
            4'b1000: begin
                if (ext == 4'b0100) begin
                    d_defined = 1'b1; d_wr = 1'b1; d_res_sel = 2'b10; d_shift_mode = 2'b00;
                end else if (ext[3:1] == 3'b000) begin
                    d_defined = 1'b1; d_wr = 1'b1; d_res_sel = 2'b10; d_shift_mode = 2'b01;
                end
            end
            4'b1111: begin d_defined = 1'b1; d_wr = 1'b1; d_res_sel = 2'b10; d_shift_mode = 2'b10; end
            4'b0100: begin
                case (ext)
                    4'b0000: begin d_defined = 1'b1; d_wr = 1'b1; d_load = 1'b1; d_res_sel = 2'b00; end
                    4'b0100: begin d_defined = 1'b1; d_stor = 1'b1; end
                    4'b1000: begin d_defined = 1'b1; d_wr = 1'b1; d_jal = 1'b1; d_res_sel = 2'b11; end
                    4'b1100: begin d_defined = 1'b1; d_jcond = 1'b1; end
                    default: ;
                endcase
            end
            4'b1100: begin d_defined = 1'b1; d_bcond = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        case (cc)
            4'b0000: cond_true = z_q;
            4'b0001: cond_true = !z_q;
            4'b0110: cond_true = n_q;
            4'b0111: cond_true = !n_q;
            4'b1000: cond_true = f_q;
            4'b1001: cond_true = !f_q;
            4'b1100: cond_true = !n_q && !z_q;
            4'b1101: cond_true = n_q || z_q;
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    // Side effects only happen for a valid IR outside scan mode.
    assign active      = ir_valid && !scan_en;
    assign load_v      = active && d_load;
    assign taken       = active && cond_true && (d_bcond || d_jcond);
    assign wr_dec      = active && d_wr && (!d_load || load_done);
    assign wr_addr_dec = wr_dec ? onehot(ir[11:8]) : '0;

    always_ff @(posedge clk) begin
        if (global_reset) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            RUN: if (load_v && HAS_LAT) begin
                state_next = LWAIT;
                cnt_next   = LAT_INIT;
            end
            LWAIT: if (scan_en || cnt == 3'd0) state_next = RUN;
                   else cnt_next = cnt - 3'd1;
            default: state_next = RUN;
        endcase
    end

    // The final LWAIT cycle releases the stall so the write-back and the next fetch coincide.
    always_comb begin
        stall     = 1'b0;
        load_done = (LOAD_LAT == 0);
        case (state)
            RUN:   stall = load_v && HAS_LAT;
            LWAIT: begin
                stall     = !scan_en && (cnt != 3'd0);
                load_done = (cnt == 3'd0);
            end
            default: ;
        endcase
    end

    assign instr_ready = !global_reset && !scan_en && !stall;

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (global_reset) begin
            ir       <= 16'h0000;
            ir_valid <= 1'b0;
        end else if (scan_en) begin
            ir       <= {ir[14:0], scan_in};
            ir_valid <= 1'b0;
        end else if (!stall) begin
            if (instr_valid) begin
                ir       <= instr_in;
                ir_valid <= !taken;
            end else begin
                ir_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (global_reset) begin
            {z_q, f_q, n_q} <= 3'b000;
        end else if (active && !stall && d_arith) begin
            {z_q, f_q, n_q} <= {Z_flag_in, F_flag_in, N_flag_in};
        end
    end

    generate
        if (WB_DELAY == 0) begin : g_wb_comb
            assign wb_en_out   = wr_dec;
            assign wb_addr_out = wr_addr_dec;
        end else begin : g_wb_pipe
            logic [WB_DELAY-1:0] en_q;
            logic [NUM_REGS-1:0] addr_q [WB_DELAY];
            always_ff @(posedge clk) begin
                if (global_reset) begin
                    en_q <= '0;
                    for (int i = 0; i < WB_DELAY; i++) addr_q[i] <= '0;
                end else begin
                    en_q[0]   <= wr_dec;
                    addr_q[0] <= wr_addr_dec;
                    for (int i = 1; i < WB_DELAY; i++) begin
                        en_q[i]   <= en_q[i-1];
                        addr_q[i] <= addr_q[i-1];
                    end
                end
            end
            assign wb_en_out   = en_q[WB_DELAY-1];
            assign wb_addr_out = addr_q[WB_DELAY-1];
        end
    endgenerate

    assign wr_en      = wb_en_out && !scan_en;
    assign wr_addr    = scan_en ? '0 : wb_addr_out;
    assign scan_out   = ir[15];
    assign rd_addr_a  = d_defined ? onehot(ir[3:0]) : '0;
    assign rd_addr_b  = d_defined ? onehot(ir[11:8]) : '0;
    assign imm        = d_defined ? ir[7:0] : 8'h00;
    assign disp       = d_bcond ? ir[7:0] : 8'h00;
    assign alu_op     = d_alu_op;
    assign cin        = d_cin;
    assign sel_b_imm  = d_sel_b_imm;
    assign inv_b      = d_inv_b;
    assign sel_mov    = d_sel_mov;
    assign res_sel    = d_res_sel;
    assign shift_mode = d_shift_mode;
    assign mem_ceb    = !(active && (d_load || d_stor));
    assign mem_web    = !(active && d_stor);
    assign bcond      = active && d_bcond && cond_true;
    assign jcond      = active && d_jcond && cond_true;
    assign jal        = active && d_jal;

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Randomised and directed bench for decode_stage_pipelined against an instruction-level model.
module tb_decode_stage_pipelined;

    localparam int NUM_REGS = 16;
    localparam int WB_DELAY = 1;
    localparam int LOAD_LAT = 2;

    logic                clk = 1'b0;
    logic                global_reset, instr_valid, instr_ready;
    logic [15:0]         instr_in;
    logic                Z_flag_in, F_flag_in, N_flag_in, scan_en, scan_in, scan_out;
    logic [NUM_REGS-1:0] rd_addr_a, rd_addr_b, wr_addr;
    logic                wr_en, cin, sel_b_imm, inv_b, sel_mov, mem_ceb, mem_web;
    logic                bcond, jcond, jal, stall;
    logic [1:0]          alu_op, res_sel, shift_mode;
    logic [7:0]          imm, disp;

    decode_stage_pipelined #(.NUM_REGS(NUM_REGS), .WB_DELAY(WB_DELAY), .LOAD_LAT(LOAD_LAT)) dut (
        .clk(clk), .global_reset(global_reset), .instr_in(instr_in), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .Z_flag_in(Z_flag_in), .F_flag_in(F_flag_in), .N_flag_in(N_flag_in),
        .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out), .rd_addr_a(rd_addr_a),
        .rd_addr_b(rd_addr_b), .wr_addr(wr_addr), .wr_en(wr_en), .alu_op(alu_op), .cin(cin),
        .sel_b_imm(sel_b_imm), .inv_b(inv_b), .sel_mov(sel_mov), .res_sel(res_sel),
        .shift_mode(shift_mode), .imm(imm), .mem_ceb(mem_ceb), .mem_web(mem_web), .bcond(bcond),
        .jcond(jcond), .jal(jal), .disp(disp), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef enum int {M_NOP, M_ADD, M_SUB, M_CMP, M_MOV, M_AND, M_OR, M_XOR,
                      M_LSH, M_LSHI, M_LUI, M_LOAD, M_STOR, M_JAL, M_JCOND, M_BCOND} mnem_t;

    int checks = 0;
    int errors = 0;

    // Instruction-level model state
    logic [15:0]         m_ir;
    bit                  m_valid, m_z, m_f, m_n;
    int                  ld_wait;
    bit                  wbq_en   [WB_DELAY];
    logic [NUM_REGS-1:0] wbq_addr [WB_DELAY];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic mnem_t classify(input logic [15:0] w, output bit immf);
        logic [3:0] opc, ext, code;
        opc = w[15:12]; ext = w[7:4]; immf = 0; code = 4'h0;
        if (opc == 4'h0) code = ext;
        else if (opc inside {4'h5, 4'h9, 4'hB, 4'hD, 4'h1, 4'h2, 4'h3}) begin code = opc; immf = 1; end
        if (opc == 4'h0 || immf) begin
            case (code)
                4'h5: return M_ADD;
                4'h9: return M_SUB;
                4'hB: return M_CMP;
                4'hD: return M_MOV;
                4'h1: return M_AND;
                4'h2: return M_OR;
                4'h3: return M_XOR;
                default: begin immf = 0; return M_NOP; end
            endcase
        end
        if (opc == 4'h8) return (ext == 4'h4) ? M_LSH : (ext == 4'h0 || ext == 4'h1) ? M_LSHI : M_NOP;
        if (opc == 4'hF) return M_LUI;
        if (opc == 4'hC) return M_BCOND;
        if (opc == 4'h4) begin
            case (ext)
                4'h0: return M_LOAD;
                4'h4: return M_STOR;
                4'h8: return M_JAL;
                4'hC: return M_JCOND;
                default: return M_NOP;
            endcase
        end
        return M_NOP;
    endfunction

    function automatic bit cond_ok(input logic [3:0] c, input bit z, input bit f, input bit n);
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h6: return n;
            4'h7: return !n;
            4'h8: return f;
            4'h9: return !f;
            4'hC: return !n && !z;
            4'hD: return n || z;
            4'hE: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [NUM_REGS-1:0] onehot_ref(input logic [3:0] i);
        logic [NUM_REGS-1:0] v = '0;
        if (int'(i) < NUM_REGS) v[i] = 1'b1;
        return v;
    endfunction

    // {alu_op, cin, sel_b_imm, inv_b, sel_mov, res_sel, shift_mode}
    function automatic logic [9:0] ctrl_ref(input mnem_t m, input bit immf);
        logic [1:0] op = 0, rs = 0, sm = 0;
        bit c = 0, sb = 0, ib = 0, mv = 0;
        case (m)
            M_ADD:        rs = 1;
            M_SUB, M_CMP: begin rs = 1; c = 1; ib = 1; end
            M_MOV:        begin rs = 1; mv = 1; end
            M_AND:        begin rs = 1; op = 1; end
            M_OR:         begin rs = 1; op = 2; end
            M_XOR:        begin rs = 1; op = 3; end
            M_LSH:        rs = 2;
            M_LSHI:       begin rs = 2; sm = 1; end
            M_LUI:        begin rs = 2; sm = 2; end
            M_JAL:        rs = 3;
            default: ;
        endcase
        sb = immf;
        return {op, c, sb, ib, mv, rs, sm};
    endfunction

    task automatic model_reset();
        m_ir = 16'h0; m_valid = 0; m_z = 0; m_f = 0; m_n = 0; ld_wait = 0;
        for (int i = 0; i < WB_DELAY; i++) begin wbq_en[i] = 0; wbq_addr[i] = '0; end
    endtask

    // Check every output at the falling edge, then advance the model across the rising edge.
    task automatic cycle();
        bit immf, di, act, stall_e, ok, wr_e, taken, defd;
        mnem_t mn;
        logic [NUM_REGS-1:0] wa_e;
        @(negedge clk);
        mn      = classify(m_ir, immf);
        defd    = (mn != M_NOP);
        act     = m_valid && !scan_en;
        stall_e = !scan_en && (ld_wait > 0);
        ok      = cond_ok(m_ir[11:8], m_z, m_f, m_n);
        wr_e    = act && (mn inside {M_ADD, M_SUB, M_MOV, M_AND, M_OR, M_XOR, M_LSH, M_LSHI,
                                     M_LUI, M_LOAD, M_JAL}) && (mn != M_LOAD || ld_wait == 0);
        wa_e    = wr_e ? onehot_ref(m_ir[11:8]) : '0;
        taken   = act && ok && (mn == M_BCOND || mn == M_JCOND);
        check("instr_ready", instr_ready, !global_reset && !scan_en && !stall_e);
        check("stall", stall, stall_e);
        check("wr_en", wr_en, !scan_en && wbq_en[WB_DELAY-1]);
        check("wr_addr", wr_addr, scan_en ? '0 : wbq_addr[WB_DELAY-1]);
        check("rd_addr_a", rd_addr_a, defd ? onehot_ref(m_ir[3:0]) : '0);
        check("rd_addr_b", rd_addr_b, defd ? onehot_ref(m_ir[11:8]) : '0);
        check("ctrl", {alu_op, cin, sel_b_imm, inv_b, sel_mov, res_sel, shift_mode}, ctrl_ref(mn, immf));
        check("imm", imm, defd ? m_ir[7:0] : 8'h00);
        check("disp", disp, (mn == M_BCOND) ? m_ir[7:0] : 8'h00);
        check("mem", {mem_ceb, mem_web}, {!(act && (mn == M_LOAD || mn == M_STOR)), !(act && mn == M_STOR)});
        check("branch", {bcond, jcond, jal}, {act && mn == M_BCOND && ok, act && mn == M_JCOND && ok,
                                              act && mn == M_JAL});
        check("scan_out", scan_out, m_ir[15]);
        @(posedge clk);
        if (global_reset) begin
            model_reset();
        end else begin
            for (int i = WB_DELAY - 1; i > 0; i--) begin
                wbq_en[i] = wbq_en[i-1]; wbq_addr[i] = wbq_addr[i-1];
            end
            wbq_en[0] = wr_e; wbq_addr[0] = wa_e;
            if (act && !stall_e && (mn inside {M_ADD, M_SUB, M_CMP}))
                {m_z, m_f, m_n} = {Z_flag_in, F_flag_in, N_flag_in};
            if (scan_en) begin
                m_ir = {m_ir[14:0], scan_in}; m_valid = 0; ld_wait = 0;
            end else if (stall_e) begin
                ld_wait--;
            end else if (instr_valid) begin
                m_ir = instr_in; m_valid = !taken;
                ld_wait = (m_valid && classify(m_ir, di) == M_LOAD) ? LOAD_LAT : 0;
            end else begin
                m_valid = 0; ld_wait = 0;
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] w);
        instr_valid = v; instr_in = w; scan_en = 1'b0;
        cycle();
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        logic [3:0] alu [7];
        alu = '{4'h5, 4'h9, 4'hB, 4'hD, 4'h1, 4'h2, 4'h3};
        w = 16'($urandom);
        case ($urandom_range(0, 6))
            1: begin w[15:12] = 4'h0; w[7:4] = alu[$urandom_range(0, 6)]; end
            2: w[15:12] = alu[$urandom_range(0, 6)];
            3: begin w[15:12] = 4'h8; w[7:4] = ($urandom_range(0, 1) == 1) ? 4'h4 : 4'($urandom_range(0, 1)); end
            4: w[15:12] = 4'hF;
            5: begin w[15:12] = 4'h4; w[7:4] = {2'($urandom_range(0, 3)), 2'b00}; end
            6: w[15:12] = 4'hC;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        logic [15:0] rd;
        logic [15:0] pat;
        global_reset = 1'b1; instr_valid = 1'b0; instr_in = 16'h0; scan_en = 1'b0; scan_in = 1'b0;
        Z_flag_in = 1'b0; F_flag_in = 1'b0; N_flag_in = 1'b0;

        // T1: two reset cycles, then release
        @(posedge clk); model_reset(); #1;
        cycle();
        global_reset = 1'b0; #1;
        check("t1_ready_after_release", instr_ready, 1'b1);

        // T2: ADD R1->R2, flags latched from Z_flag_in=1
        Z_flag_in = 1'b1;
        drive(1'b1, 16'h0251);
        check("t2_rd_a", rd_addr_a, 16'h0002);
        check("t2_rd_b", rd_addr_b, 16'h0004);
        check("t2_alu_op", alu_op, 2'b00);
        drive(1'b0, 16'h0000);
        check("t2_wr_en", wr_en, 1'b1);
        check("t2_wr_addr", wr_addr, 16'h0004);

        // T3: BEQ taken squashes the following word, not taken lets it through
        Z_flag_in = 1'b0;
        drive(1'b1, 16'hC005);
        check("t3_bcond_taken", bcond, 1'b1);
        check("t3_disp", disp, 8'h05);
        drive(1'b1, 16'h0251);
        drive(1'b0, 16'h0000);
        check("t3_squashed_no_wr", wr_en, 1'b0);
        drive(1'b1, 16'h0251);
        drive(1'b1, 16'hC005);
        check("t3_bcond_not_taken", bcond, 1'b0);
        drive(1'b1, 16'h0251);
        drive(1'b0, 16'h0000);
        check("t3_not_squashed_wr", wr_en, 1'b1);

        // T4: LOAD with LOAD_LAT=2
        drive(1'b1, 16'h4003);
        check("t4_stall_a", stall, 1'b1);
        check("t4_ready_a", instr_ready, 1'b0);
        check("t4_mem_ceb", mem_ceb, 1'b0);
        drive(1'b1, 16'h0251);
        check("t4_stall_b", stall, 1'b1);
        drive(1'b1, 16'h0251);
        check("t4_stall_released", stall, 1'b0);
        check("t4_no_early_wr", wr_en, 1'b0);
        drive(1'b1, 16'h0251);
        check("t4_load_wr_en", wr_en, 1'b1);
        check("t4_load_wr_addr", wr_addr, 16'h0001);
        check("t4_next_accepted", rd_addr_b, 16'h0004);
        drive(1'b0, 16'h0000);

        // T5: scan 0xD37F in, then read it back out
        pat = 16'hD37F;
        instr_valid = 1'b0; scan_en = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            scan_in = pat[i];
            cycle();
        end
        check("t5_movi_rd_b", rd_addr_b, 16'h0008);
        check("t5_movi_sel_mov", sel_mov, 1'b1);
        check("t5_movi_imm", {sel_b_imm, imm}, 9'h17F);
        rd = 16'h0;
        for (int i = 0; i < 16; i++) begin
            rd = {rd[14:0], scan_out};
            scan_in = 1'b0;
            cycle();
        end
        check("t5_scan_readout", rd, 16'hD37F);
        scan_en = 1'b0;

        // T6: reset in LWAIT, during scan, and with a write in flight
        drive(1'b1, 16'h4003);
        drive(1'b0, 16'h0000);
        global_reset = 1'b1; cycle();
        global_reset = 1'b0; #1;
        check("t6_lwait_reset_stall", stall, 1'b0);
        check("t6_lwait_reset_ready", instr_ready, 1'b1);
        check("t6_lwait_reset_wr", wr_en, 1'b0);
        scan_en = 1'b1; scan_in = 1'b1; cycle(); cycle();
        global_reset = 1'b1; cycle();
        global_reset = 1'b0; scan_en = 1'b0; #1;
        check("t6_scan_reset_ready", instr_ready, 1'b1);
        check("t6_scan_reset_ir", scan_out, 1'b0);
        drive(1'b1, 16'h0251);
        global_reset = 1'b1; instr_valid = 1'b0; cycle();
        global_reset = 1'b0; #1;
        check("t6_inflight_dropped", wr_en, 1'b0);

        // Randomised traffic against the model
        for (int k = 0; k < 800; k++) begin
            global_reset = ($urandom_range(0, 63) == 0);
            scan_en      = ($urandom_range(0, 15) == 0);
            scan_in      = 1'($urandom_range(0, 1));
            instr_valid  = ($urandom_range(0, 3) != 0);
            instr_in     = rand_instr();
            Z_flag_in    = 1'($urandom_range(0, 1));
            F_flag_in    = 1'($urandom_range(0, 1));
            N_flag_in    = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
